sram_rd_arbiter: RTL and testbench

SRAM_RD_ARBITER -- requirements
Module: sram_rd_arbiter

---
 rtl/sram_rd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_rd_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rd_arbiter.sv
// Read-channel arbiter between the IFU (m0) and LSU (m1) masters in front of one SRAM slave.
// A grant covers exactly one AR/R transaction. The granted master's channels are routed
// straight through to the SRAM. The master that is not granted sees ready/valid low and
// zero data and response.
//
// Ports
//   clk, rst_n                  : clock and asynchronous active-low reset
//   m0_* (IFU), m1_* (LSU)      : master-side AR/R channels
//   s_*                         : SRAM-side AR/R channels
//   grant_id                    : current owner (0 = IFU, 1 = LSU), meaningful while busy
//   busy                        : high whenever a transaction owns the SRAM
//
// Configuration
//   ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate using a last_grant
//                        register. When undefined, the LSU has fixed priority over the IFU.
module sram_rd_arbiter #(
   parameter int unsigned DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   // IFU side
   input  logic                m0_arvalid,
   output logic                m0_arready,
   input  logic [DATA_LEN-1:0] m0_araddr,
   output logic [DATA_LEN-1:0] m0_rdata,
   output logic                m0_rvalid,
   output logic [2:0]          m0_rresp,
   input  logic                m0_rready,
   // LSU side
   input  logic                m1_arvalid,
   output logic                m1_arready,
   input  logic [DATA_LEN-1:0] m1_araddr,
   output logic [DATA_LEN-1:0] m1_rdata,
   output logic                m1_rvalid,
   output logic [2:0]          m1_rresp,
   input  logic                m1_rready,
   // SRAM side
   output logic                s_arvalid,
   input  logic                s_arready,
   output logic [DATA_LEN-1:0] s_araddr,
   input  logic [DATA_LEN-1:0] s_rdata,
   input  logic                s_rvalid,
   input  logic [2:0]          s_rresp,
   output logic                s_rready,
   // status
   output logic                grant_id,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10
   } state_t;

   state_t state;
   state_t state_next;
   logic   grant;
   logic   grant_next;
   logic   winner;
   logic   fwd_r;
   logic   sel_arvalid;
   logic   sel_rready;

`ifdef ARB_ROUND_ROBIN_EN
   logic   last_grant;
   logic   last_grant_next;
`endif

   // State, grant and arbitration history registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant <= 1'b1;
`endif
      end else begin
         state      <= state_next;
         grant      <= grant_next;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant <= last_grant_next;
`endif
      end
   end

   // Next-state logic and combinational routing of the granted master
   always_comb begin
      state_next  = state;
      grant_next  = grant;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_next = last_grant;
`endif
      winner      = 1'b0;
      fwd_r       = 1'b0;
      sel_arvalid = grant ? m1_arvalid : m0_arvalid;
      sel_rready  = grant ? m1_rready  : m0_rready;

      s_arvalid   = 1'b0;
      s_araddr    = '0;
      s_rready    = 1'b0;
      m0_arready  = 1'b0;
      m1_arready  = 1'b0;
      m0_rvalid   = 1'b0;
      m1_rvalid   = 1'b0;
      m0_rdata    = '0;
      m1_rdata    = '0;
      m0_rresp    = 3'b000;
      m1_rresp    = 3'b000;

      case (state)
         IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
               // On contention, the master that was not served last time wins
               winner          = (m0_arvalid && m1_arvalid) ? ~last_grant : m1_arvalid;
               last_grant_next = winner;
`else
               winner          = m1_arvalid;
`endif
               grant_next = winner;
               state_next = ADDR;
            end
         end

         ADDR: begin
            s_arvalid  = sel_arvalid;
            s_araddr   = grant ? m1_araddr : m0_araddr;
            m0_arready = !grant && s_arready;
            m1_arready =  grant && s_arready;
            fwd_r      = 1'b1;
            // A dropped arvalid means no SRAM handshake could have occurred
            if (!sel_arvalid)
               state_next = IDLE;
            else if (s_arready && s_rvalid && sel_rready)
               state_next = IDLE;
            else if (s_arready)
               state_next = DATA;
         end

         DATA: begin
            fwd_r = 1'b1;
            if (s_rvalid && sel_rready)
               state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
            grant_next = 1'b0;
         end
      endcase

      // The R channel is routed while a transaction is in flight; the response is forwarded unchanged
      if (fwd_r) begin
         s_rready = sel_rready;
         if (grant) begin
            m1_rvalid = s_rvalid;
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
         end else begin
            m0_rvalid = s_rvalid;
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
         end
      end
   end

   assign busy     = (state != IDLE);
   assign grant_id = busy && grant;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed self-checking bench for sram_rd_arbiter. The bench plays the SRAM by hand,
// so every SRAM response is driven explicitly in each scenario.
module tb_sram_rd_arbiter;

   localparam int unsigned DL = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [DL-1:0] m0_araddr, m0_rdata;
   logic [2:0]    m0_rresp;
   logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [DL-1:0] m1_araddr, m1_rdata;
   logic [2:0]    m1_rresp;
   logic          s_arvalid, s_arready, s_rvalid, s_rready;
   logic [DL-1:0] s_araddr, s_rdata;
   logic [2:0]    s_rresp;
   logic          grant_id, busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sram_rd_arbiter #(.DATA_LEN(DL)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rready(s_rready),
      .grant_id(grant_id), .busy(busy)
   );

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_arvalid = 1'b0; m0_araddr = '0; m0_rready = 1'b1;
      m1_arvalid = 1'b0; m1_araddr = '0; m1_rready = 1'b1;
      s_arready  = 1'b0; s_rdata   = '0; s_rvalid  = 1'b0; s_rresp = 3'b000;
   endtask

   task automatic test_reset();
      clear_inputs();
      m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_rvalid = 1'b1; s_arready = 1'b1;
      rst_n = 1'b0;
      tick(); tick();
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests++; if (grant_id !== 1'b0)  begin fails++; $display("FAIL reset_grant got=%b exp=0", grant_id); end
      tests++; if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0)
         begin fails++; $display("FAIL reset_hs got=%b exp=000000", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}); end
      tests++; if (s_araddr !== 32'h0) begin fails++; $display("FAIL reset_araddr got=%h exp=0", s_araddr); end
      clear_inputs();
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ifu_zero_wait();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000;
      #1;
      tests++; if (s_arvalid !== 1'b0 || busy !== 1'b0)
         begin fails++; $display("FAIL ifu_idle_no_sram got=%b%b exp=00", s_arvalid, busy); end
      tick();                                  // ADDR
      s_arready = 1'b1;
      #1;
      tests++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000)
         begin fails++; $display("FAIL ifu_ar got=%b/%h exp=1/80000000", s_arvalid, s_araddr); end
      tests++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0 || grant_id !== 1'b0 || busy !== 1'b1)
         begin fails++; $display("FAIL ifu_grant got=%b%b%b%b exp=1001", m0_arready, m1_arready, grant_id, busy); end
      tick();                                  // DATA
      m0_arvalid = 1'b0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h0000_0413;
      #1;
      tests++; if (s_arvalid !== 1'b0) begin fails++; $display("FAIL ifu_data_no_ar got=%b exp=0", s_arvalid); end
      tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_0413 || s_rready !== 1'b1)
         begin fails++; $display("FAIL ifu_rdata got=%b/%h/%b exp=1/00000413/1", m0_rvalid, m0_rdata, s_rready); end
      tests++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || m1_rresp !== 3'b000)
         begin fails++; $display("FAIL ifu_m1_quiet got=%b/%h/%b exp=0/0/000", m1_rvalid, m1_rdata, m1_rresp); end
      tick();                                  // IDLE
      s_rvalid = 1'b0; s_rdata = '0;
      #1;
      tests++; if (busy !== 1'b0 || m0_rvalid !== 1'b0)
         begin fails++; $display("FAIL ifu_done got=%b%b exp=00", busy, m0_rvalid); end
   endtask

   task automatic test_same_cycle();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0010;
      tick();                                  // ADDR
      s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 3'b000;
      #1;
      tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m0_arready !== 1'b1)
         begin fails++; $display("FAIL same_cycle_r got=%b/%h/%b exp=1/deadbeef/1", m0_rvalid, m0_rdata, m0_arready); end
      tick();
      clear_inputs();
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL same_cycle_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_abort();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0020;
      tick();                                  // ADDR
      m0_arvalid = 1'b0;
      #1;
      tests++; if (s_arvalid !== 1'b0 || busy !== 1'b1)
         begin fails++; $display("FAIL abort_addr got=%b%b exp=01", s_arvalid, busy); end
      tick();
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle busy=%b exp=0", busy); end
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   task automatic test_round_robin();
      logic [3:0] exp_g;
      exp_g = 4'b1010;                         // bit i = expected grant i: 0,1,0,1
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      clear_inputs();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0004;
      m1_arvalid = 1'b1; m1_araddr = 32'h8000_1000;
      tick();                                  // IDLE evaluated at this edge
      for (int i = 0; i < 4; i++) begin
         tests++; if (busy !== 1'b1 || grant_id !== exp_g[i])
            begin fails++; $display("FAIL rr_grant%0d got=%b/%b exp=1/%b", i, busy, grant_id, exp_g[i]); end
         s_arready = 1'b1; s_rvalid = 1'b1;
         tick();
         s_arready = 1'b0; s_rvalid = 1'b0;
         #1;
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_gap%0d busy=%b exp=0", i, busy); end
         tick();
      end
      clear_inputs();
      tick();
   endtask
`else
   task automatic test_priority();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0004;
      m1_arvalid = 1'b1; m1_araddr = 32'h8000_1000;
      tick();                                  // ADDR, LSU granted
      s_arready = 1'b1; s_rvalid = 1'b1;
      #1;
      tests++; if (grant_id !== 1'b1 || s_araddr !== 32'h8000_1000 || m0_arready !== 1'b0)
         begin fails++; $display("FAIL prio_lsu got=%b/%h/%b exp=1/80001000/0", grant_id, s_araddr, m0_arready); end
      tick();                                  // IDLE gap
      m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_gap busy=%b exp=0", busy); end
      tick();                                  // ADDR, IFU granted
      s_arready = 1'b1; s_rvalid = 1'b1;
      #1;
      tests++; if (grant_id !== 1'b0 || s_araddr !== 32'h8000_0004 || m0_rvalid !== 1'b1)
         begin fails++; $display("FAIL prio_ifu got=%b/%h/%b exp=0/80000004/1", grant_id, s_araddr, m0_rvalid); end
      tick();
      clear_inputs();
      tick();
   endtask
`endif

   task automatic test_error_resp();
      m1_arvalid = 1'b1; m1_araddr = 32'h8000_2000;
      tick();                                  // ADDR, LSU
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0030;   // arrives mid-transaction
      s_arready = 1'b1;
      #1;
      tests++; if (grant_id !== 1'b1 || m0_arready !== 1'b0 || m1_arready !== 1'b1)
         begin fails++; $display("FAIL err_grant got=%b%b%b exp=101", grant_id, m0_arready, m1_arready); end
      tick();                                  // DATA
      m1_arvalid = 1'b0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rresp = 3'b010; s_rdata = 32'h1234_5678;
      #1;
      tests++; if (m1_rresp !== 3'b010 || m1_rvalid !== 1'b1 || m1_rdata !== 32'h1234_5678)
         begin fails++; $display("FAIL err_resp got=%b/%b/%h exp=010/1/12345678", m1_rresp, m1_rvalid, m1_rdata); end
      tests++; if (m0_rvalid !== 1'b0 || m0_rresp !== 3'b000 || m0_rdata !== 32'h0)
         begin fails++; $display("FAIL err_m0_quiet got=%b/%b/%h exp=0/000/0", m0_rvalid, m0_rresp, m0_rdata); end
      tick();                                  // IDLE
      s_rvalid = 1'b0; s_rresp = 3'b000; s_rdata = '0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL err_idle busy=%b exp=0", busy); end
      tick();                                  // ADDR, pending IFU
      s_arready = 1'b1; s_rvalid = 1'b1;
      #1;
      tests++; if (grant_id !== 1'b0 || s_araddr !== 32'h8000_0030)
         begin fails++; $display("FAIL err_next got=%b/%h exp=0/80000030", grant_id, s_araddr); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_in_data();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0040;
      tick();                                  // ADDR
      s_arready = 1'b1;
      tick();                                  // DATA, waiting on rvalid
      m0_arvalid = 1'b0; s_arready = 1'b0;
      #1;
      tests++; if (busy !== 1'b1 || s_rready !== 1'b1)
         begin fails++; $display("FAIL rstd_wait got=%b%b exp=11", busy, s_rready); end
      #1 rst_n = 1'b0;
      s_rvalid = 1'b1;
      #1;
      tests++; if ({busy, s_rready, m0_rvalid, m1_rvalid} !== 4'b0000)
         begin fails++; $display("FAIL rstd_async got=%b exp=0000", {busy, s_rready, m0_rvalid, m1_rvalid}); end
      tick();
      clear_inputs();
      #2 rst_n = 1'b1;
      tick();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0050;
      tick();                                  // ADDR
      s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_00AA;
      #1;
      tests++; if (grant_id !== 1'b0 || s_araddr !== 32'h8000_0050 || m0_rdata !== 32'h0000_00AA)
         begin fails++; $display("FAIL rstd_after got=%b/%h/%h exp=0/80000050/000000aa", grant_id, s_araddr, m0_rdata); end
      tick();
      clear_inputs();
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstd_end busy=%b exp=0", busy); end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_ifu_zero_wait();
      test_same_cycle();
      test_abort();
`ifdef ARB_ROUND_ROBIN_EN
      test_round_robin();
`else
      test_priority();
`endif
      test_error_resp();
      test_reset_in_data();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
